// File: rtl/song_event_reader_pkg.sv
// Shared definitions for the song event reader:
// entry field layout, end marker and FSM state encoding.
package song_event_reader_pkg;

  localparam int ENTRY_WIDTH = 16;

  localparam int TYPE_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int META_MSB = 2;
  localparam int META_LSB = 0;

  localparam logic [ENTRY_WIDTH-1:0] END_MARKER = 16'h0000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_ROM = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_WAIT_ADV = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_WAIT_ROM = ST_WAIT_ROM,
    S_ISSUE    = ST_ISSUE,
    S_WAIT_ADV = ST_WAIT_ADV,
    S_DONE     = ST_DONE
  } state_e;

  typedef struct packed {
    logic       type_signal;
    logic [5:0] note;
    logic [5:0] duration;
    logic [2:0] meta;
  } entry_t;

endpackage

// File: rtl/song_entry_decoder.sv
// Splits one 16-bit song entry into its fields.
// Purely combinational; is_end flags the end marker.
module song_entry_decoder
  import song_event_reader_pkg::*;
(
  input  logic [ENTRY_WIDTH-1:0] entry,
  output logic [5:0]             note,
  output logic [5:0]             duration,
  output logic [2:0]             meta,
  output logic                   type_signal,
  output logic                   is_end
);

  assign note        = entry[NOTE_MSB:NOTE_LSB];
  assign duration    = entry[DUR_MSB:DUR_LSB];
  assign meta        = entry[META_MSB:META_LSB];
  assign type_signal = entry[TYPE_BIT];
  assign is_end      = (entry == END_MARKER);

endmodule

// File: rtl/song_event_reader.sv
// Walks a song ROM, issuing one decoded entry per load_count
// and parking on wait entries until advance arrives.
module song_event_reader
  import song_event_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int SONG_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play_enable,
  input  logic                           new_song,
  input  logic [SONG_WIDTH-1:0]          song,
  input  logic                           advance,
  input  logic [ENTRY_WIDTH-1:0]         rom_data,
  output logic [SONG_WIDTH+ADDR_WIDTH-1:0] rom_addr,
  output logic [5:0]                     note,
  output logic [5:0]                     duration,
  output logic [2:0]                     meta,
  output logic                           type_signal,
  output logic                           load_count,
  output logic                           song_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] index_q;
  logic [ADDR_WIDTH-1:0] index_d;
  logic [SONG_WIDTH-1:0] song_q;
  logic [SONG_WIDTH-1:0] song_d;
  logic                  capture;
  logic                  last;
  entry_t                fields_q;
  entry_t                dec;
  logic                  dec_end;

  song_entry_decoder u_dec (
    .entry       (rom_data),
    .note        (dec.note),
    .duration    (dec.duration),
    .meta        (dec.meta),
    .type_signal (dec.type_signal),
    .is_end      (dec_end)
  );

  assign last = (index_q == LAST_INDEX);

  // Next state, next index/song and field capture strobe.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    song_d  = song_q;
    capture = 1'b0;
    if (new_song) begin
      state_d = S_FETCH;
      index_d = '0;
      song_d  = song;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (play_enable) begin
            state_d = S_FETCH;
            index_d = '0;
            song_d  = song;
          end
        end
        S_FETCH: begin
          if (play_enable) state_d = S_WAIT_ROM;
        end
        S_WAIT_ROM: begin
          if (dec_end) begin
            state_d = S_DONE;
          end else begin
            capture = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fields_q.type_signal && |fields_q.duration) begin
            state_d = S_WAIT_ADV;
          end else if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            index_d = index_q + 1'b1;
          end
        end
        S_WAIT_ADV: begin
          if (advance && play_enable) begin
            if (last) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FETCH;
              index_d = index_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, index and selected-song registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      song_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      song_q  <= song_d;
    end
  end

  // Decoded fields hold until the next entry is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      fields_q <= '0;
    end else if (capture) begin
      fields_q <= dec;
    end
  end

  // ROM address moves only when FETCH is (re)entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (state_d == S_FETCH) begin
      rom_addr <= {song_d, index_d};
    end
  end

  assign note        = fields_q.note;
  assign duration    = fields_q.duration;
  assign meta        = fields_q.meta;
  assign type_signal = fields_q.type_signal;
  assign load_count  = (state_q == S_ISSUE);
  assign song_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_song_event_reader.sv
// Bench for song_event_reader: directed scenarios plus random
// stimulus, all checked each cycle against an entry-level model.
module tb_song_event_reader;

  logic        clk;
  logic        reset;
  logic        play_enable;
  logic        new_song;
  logic [1:0]  song;
  logic        advance;
  logic [15:0] rom_data;
  logic [8:0]  rom_addr;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic [2:0]  meta;
  logic        type_signal;
  logic        load_count;
  logic        song_done;

  logic [15:0] rom [0:511];

  int n_checks = 0;
  int n_err    = 0;
  int n_loads  = 0;
  bit chk_en   = 0;

  song_event_reader #(.ADDR_WIDTH(7), .SONG_WIDTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .play_enable (play_enable),
    .new_song    (new_song),
    .song        (song),
    .advance     (advance),
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .note        (note),
    .duration    (duration),
    .meta        (meta),
    .type_signal (type_signal),
    .load_count  (load_count),
    .song_done   (song_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Entry-level model: where we are in the song and in the entry.
  bit          m_active;
  bit          m_fin;
  int          m_song;
  int          m_pos;
  int          m_step;
  logic [15:0] m_cur;

  task automatic m_next();
    if (m_pos == 127) m_fin = 1;
    else begin
      m_pos++;
      m_step = 0;
    end
  endtask

  always @(posedge clk) begin
    logic [15:0] e;
    if (reset) begin
      m_active = 0; m_fin = 0; m_song = 0;
      m_pos = 0; m_step = 0; m_cur = 0;
    end else if (new_song) begin
      m_active = 1; m_fin = 0; m_song = int'(song);
      m_pos = 0; m_step = 0;
    end else if (!m_active) begin
      if (play_enable) begin
        m_active = 1; m_song = int'(song);
        m_pos = 0; m_step = 0;
      end
    end else if (!m_fin) begin
      case (m_step)
        0: if (play_enable) m_step = 1;
        1: begin
          e = rom[m_song * 128 + m_pos];
          if (e == 0) m_fin = 1;
          else begin
            m_cur = e;
            m_step = 2;
          end
        end
        2: begin
          if (m_cur >= 16'h8000 && ((m_cur >> 3) & 63) != 0)
            m_step = 3;
          else m_next();
        end
        default: if (advance && play_enable) m_next();
      endcase
    end
  end

  function automatic logic [26:0] exp_vec();
    logic ld;
    ld = m_active && !m_fin && m_step == 2;
    return {9'(m_song * 128 + m_pos), 6'(m_cur >> 9),
            6'(m_cur >> 3), 3'(m_cur), 1'(m_cur >> 15),
            ld, m_fin};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs with the model.
  always @(negedge clk) begin
    if (chk_en)
      check("outputs",
            {5'd0, rom_addr, note, duration, meta,
             type_signal, load_count, song_done},
            {5'd0, exp_vec()});
  end

  task automatic tick();
    @(negedge clk);
    if (load_count === 1'b1) n_loads++;
  endtask

  task automatic wait_load(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (load_count !== 1'b1 && cyc < 20);
    if (load_count !== 1'b1) check("load_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int snap;
    reset = 1; play_enable = 0; new_song = 0;
    song = 0; advance = 0;
    for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
    rom[0]   = 16'h1820;
    rom[1]   = 16'h8040;
    rom[128] = 16'h8A00;
    rom[129] = 16'h0E08;
    for (int i = 0; i < 128; i++) rom[384 + i] = 16'h0200 | 16'(i);
    @(posedge clk);
    chk_en = 1;
    repeat (3) tick();
    check("rst_addr", rom_addr, 0);
    check("rst_load", load_count, 0);
    check("rst_done", song_done, 0);
    check("rst_note", note, 0);

    reset = 0; play_enable = 1;
    n_loads = 0;
    wait_load(cyc);
    check("first_latency", cyc, 3);
    check("first_note", note, 12);
    check("first_type", type_signal, 0);
    check("first_dur", duration, 4);
    wait_load(cyc);
    check("second_gap", cyc, 3);
    check("second_type", type_signal, 1);
    check("second_dur", duration, 8);
    repeat (6) tick();
    check("wait_addr_hold", rom_addr, 1);
    advance = 1;
    tick();
    advance = 0;
    repeat (4) tick();
    check("end_done", song_done, 1);
    check("end_addr", rom_addr, 2);
    check("end_loads", n_loads, 2);

    new_song = 1; song = 0;
    tick();
    new_song = 0;
    wait_load(cyc);
    wait_load(cyc);
    tick();
    new_song = 1; song = 2; advance = 1;
    tick();
    check("newsong_addr", rom_addr, 9'h100);
    check("newsong_done", song_done, 0);
    new_song = 0;
    repeat (5) tick();

    new_song = 1; song = 1;
    tick();
    new_song = 0; play_enable = 0;
    snap = n_loads;
    repeat (10) tick();
    check("pause_addr", rom_addr, 9'h080);
    check("pause_loads", n_loads - snap, 0);
    play_enable = 1;
    wait_load(cyc);
    check("w0_type", type_signal, 1);
    check("w0_note", note, 5);
    check("w0_dur", duration, 0);
    wait_load(cyc);
    check("w0_gap", cyc, 3);
    check("w0_next_note", note, 7);
    advance = 0;
    repeat (5) tick();

    new_song = 1; song = 3;
    tick();
    new_song = 0;
    n_loads = 0;
    repeat (128 * 3 + 10) tick();
    check("full_loads", n_loads, 128);
    check("full_done", song_done, 1);
    check("full_addr", rom_addr, 9'h1FF);

    new_song = 1; song = 3;
    tick();
    new_song = 0;
    wait_load(cyc);
    reset = 1;
    tick();
    check("rst_issue_load", load_count, 0);
    check("rst_issue_fields",
          {note, duration, meta, type_signal}, 0);
    check("rst_issue_addr", rom_addr, 0);
    check("rst_issue_done", song_done, 0);

    for (int i = 0; i < 512; i++) begin
      int r;
      logic [15:0] e;
      r = $urandom_range(0, 99);
      e = 16'($urandom) & 16'h7FFF;
      if (r < 3) e = 16'h0000;
      else if (r < 40) begin
        e = e | 16'h8000;
        if ($urandom_range(0, 2) == 0) e = e & 16'hFE07;
      end
      if (e == 16'h0000 && r >= 3) e = 16'h0001;
      rom[i] = e;
    end
    tick();
    reset = 0;
    for (int k = 0; k < 4000; k++) begin
      play_enable = ($urandom_range(0, 9) < 8);
      advance     = ($urandom_range(0, 9) < 3);
      new_song    = ($urandom_range(0, 39) == 0);
      song        = 2'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0; new_song = 0; advance = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
